// File: rtl/snake_pkg.sv
// Shared types and helpers for the 8x8 snake game controller.
package snake_pkg;

    localparam int GRID_DIM = 8;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } cell_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_COMMIT,
        ST_FOOD,
        ST_DEAD
    } state_t;

    // Coordinates are 3 bits, so the +/-1 wraps around the grid edge for free.
    function automatic cell_t step_cell(input cell_t c, input dir_t d);
        cell_t n;
        n = c;
        unique case (d)
            DIR_UP:    n.y = c.y - 3'd1;
            DIR_RIGHT: n.x = c.x + 3'd1;
            DIR_DOWN:  n.y = c.y + 3'd1;
            DIR_LEFT:  n.x = c.x - 3'd1;
        endcase
        return n;
    endfunction

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (x^6 + x^5 + 1) used to pick food cells.
module snake_lfsr #(
    parameter logic [5:0] SEED = 6'h2D
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic [5:0] o_value
);

    logic [5:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/snake_controller.sv
// Snake game sequencer: occupancy grid, body ring buffer, head/food tracking
// and the IDLE/CALC/COMMIT/FOOD/DEAD move sequencer.
module snake_controller
    import snake_pkg::*;
#(
    parameter int         MAX_LEN   = 16,
    parameter logic [2:0] START_X   = 3'd4,
    parameter logic [2:0] START_Y   = 3'd0,
    parameter logic [5:0] LFSR_SEED = 6'h2D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic       food_wr,
    input  logic [2:0] food_wr_x,
    input  logic [2:0] food_wr_y,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic [2:0] head_x,
    output logic [2:0] head_y,
    output logic [2:0] food_x,
    output logic [2:0] food_y,
    output logic [5:0] length,
    output logic       alive,
    output logic       busy,
    output logic       done
);

    localparam int         PW         = $clog2(MAX_LEN);
    localparam logic [5:0] MAX_LEN6   = 6'(MAX_LEN);
    localparam cell_t      START_CELL = '{x: START_X, y: START_Y};

    typedef logic [PW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (int'(p) == MAX_LEN - 1) ? '0 : p + ptr_t'(1);
    endfunction

    state_t     r_state, w_state_nxt;
    logic [7:0] r_grid [GRID_DIM];
    cell_t      r_body [MAX_LEN];
    ptr_t       r_head_ptr, r_tail_ptr;
    cell_t      r_head, r_food, r_nxt;
    logic [5:0] r_len;
    logic       r_alive, r_done, r_eat, r_on_food;
    dir_t       r_cur_dir, r_pend_dir;

    dir_t       w_dir_in;
    cell_t      w_nxt, w_tail, w_cand;
    logic       w_food_hit, w_eat, w_hit, w_cand_free;
    logic [5:0] w_lfsr;
    ptr_t       w_head_inc;

    assign w_dir_in    = dir_t'(dir);
    assign w_nxt       = step_cell(r_head, r_pend_dir);
    assign w_tail      = r_body[r_tail_ptr];
    assign w_food_hit  = (w_nxt == r_food);
    assign w_eat       = w_food_hit && (r_len < MAX_LEN6);
    // The tail cell is vacated this move unless we grow, so it is not a collision.
    assign w_hit       = r_grid[w_nxt.y][~w_nxt.x] && !((w_nxt == w_tail) && !w_eat);
    assign w_cand      = '{x: w_lfsr[2:0], y: w_lfsr[5:3]};
    assign w_cand_free = !r_grid[w_cand.y][~w_cand.x];
    assign w_head_inc  = ptr_inc(r_head_ptr);

    snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_en    (r_state == ST_FOOD),
        .o_value (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FOOD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (!food_wr && step) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC:   w_state_nxt = w_hit ? ST_DEAD : ST_COMMIT;
            ST_COMMIT: w_state_nxt = r_on_food ? ST_FOOD : ST_IDLE;
            ST_FOOD:   w_state_nxt = w_cand_free ? ST_IDLE : ST_FOOD;
            ST_DEAD:   w_state_nxt = ST_DEAD;
            default:   w_state_nxt = ST_DEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < GRID_DIM; i++) begin
                r_grid[i] <= '0;
            end
            r_grid[START_Y][~START_X] <= 1'b1;
            r_body[0]  <= START_CELL;
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_head     <= START_CELL;
            r_food     <= '0;
            r_nxt      <= '0;
            r_len      <= 6'd1;
            r_alive    <= 1'b1;
            r_done     <= 1'b0;
            r_eat      <= 1'b0;
            r_on_food  <= 1'b0;
            r_cur_dir  <= DIR_RIGHT;
            r_pend_dir <= DIR_RIGHT;
        end else begin
            r_done <= (w_state_nxt == ST_IDLE || w_state_nxt == ST_DEAD)
                      && (r_state != ST_IDLE && r_state != ST_DEAD);

            if (dir_valid && (w_dir_in != reverse_dir(r_cur_dir))) begin
                r_pend_dir <= w_dir_in;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (food_wr) begin
                        r_food <= '{x: food_wr_x, y: food_wr_y};
                    end
                end
                ST_CALC: begin
                    r_cur_dir <= r_pend_dir;
                    r_nxt     <= w_nxt;
                    r_eat     <= w_eat;
                    r_on_food <= w_food_hit;
                    if (w_hit) begin
                        r_alive <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    r_body[w_head_inc] <= r_nxt;
                    r_head_ptr         <= w_head_inc;
                    r_head             <= r_nxt;
                    if (r_eat) begin
                        r_len <= r_len + 6'd1;
                    end else begin
                        if (w_tail != r_nxt) begin
                            r_grid[w_tail.y][~w_tail.x] <= 1'b0;
                        end
                        r_tail_ptr <= ptr_inc(r_tail_ptr);
                    end
                    r_grid[r_nxt.y][~r_nxt.x] <= 1'b1;
                end
                ST_FOOD: begin
                    if (w_cand_free) begin
                        r_food <= w_cand;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data = r_grid[rd_row];
    assign head_x  = r_head.x;
    assign head_y  = r_head.y;
    assign food_x  = r_food.x;
    assign food_y  = r_food.y;
    assign length  = r_len;
    assign alive   = r_alive;
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_DEAD);
    assign done    = r_done;

endmodule

// File: tb/tb_snake_controller.sv
// Directed-vector bench for snake_controller with hand-computed expectations.
module tb_snake_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       food_wr = 1'b0;
    logic [2:0] food_wr_x = 3'd0;
    logic [2:0] food_wr_y = 3'd0;
    logic [2:0] rd_row = 3'd0;
    logic [7:0] rd_data;
    logic [2:0] head_x, head_y, food_x, food_y;
    logic [5:0] length;
    logic       alive, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    snake_controller #(
        .MAX_LEN   (16),
        .START_X   (3'd4),
        .START_Y   (3'd0),
        .LFSR_SEED (6'h2D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .dir_valid (dir_valid),
        .dir       (dir),
        .food_wr   (food_wr),
        .food_wr_x (food_wr_x),
        .food_wr_y (food_wr_y),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .head_x    (head_x),
        .head_y    (head_y),
        .food_x    (food_x),
        .food_y    (food_y),
        .length    (length),
        .alive     (alive),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 200 && busy; n++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_idle("reset_idle");
    endtask

    task automatic do_step(output int dones);
        step = 1'b1;
        tick();
        step = 1'b0;
        dones = 0;
        for (int n = 0; n < 200; n++) begin
            if (done) dones++;
            if (!busy) break;
            tick();
        end
        check("step_timeout", 32'(busy), 32'd0);
    endtask

    task automatic food_write(input logic [2:0] x, input logic [2:0] y);
        food_wr   = 1'b1;
        food_wr_x = x;
        food_wr_y = y;
        tick();
        food_wr = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir       = d;
        tick();
        dir_valid = 1'b0;
    endtask

    task automatic check_row(input string tag, input logic [2:0] r, input logic [7:0] exp);
        rd_row = r;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_head(input string tag, input logic [2:0] x, input logic [2:0] y);
        check(tag, 32'({head_x, head_y}), 32'({x, y}));
    endtask

    task automatic check_food_free(input string tag);
        int idx;
        idx    = 7 - int'(food_x);
        rd_row = food_y;
        #1;
        check(tag, 32'(rd_data[idx]), 32'd0);
    endtask

    initial begin
        int d;

        // Reset state, sampled while reset is held.
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_len", 32'(length), 32'd1);
        check_head("rst_head", 3'd4, 3'd0);
        check("rst_alive", 32'(alive), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        wait_idle("init_idle");
        check_row("init_row0", 3'd0, 8'b0000_1000);
        check("init_food_not_head", 32'({food_x, food_y} == {3'd4, 3'd0}), 32'd0);
        check_food_free("init_food_free");

        // Straight run right with wrap at x=7.
        food_write(3'd0, 3'd7);
        check("fw_food", 32'({food_x, food_y}), 32'({3'd0, 3'd7}));
        for (int i = 0; i < 4; i++) begin
            do_step(d);
            check_head("run_head", 3'((5 + i) % 8), 3'd0);
            check("run_done", 32'(d), 32'd1);
        end
        check_row("run_row0", 3'd0, 8'b1000_0000);
        check("run_len", 32'(length), 32'd1);

        // Reverse direction is dropped; a legal turn takes effect.
        do_reset();
        set_dir(2'd3);
        do_step(d);
        check_head("rev_head", 3'd5, 3'd0);
        set_dir(2'd2);
        do_step(d);
        check_head("turn_head", 3'd5, 3'd1);
        check_row("turn_row1", 3'd1, 8'b0000_0100);
        check_row("turn_row0", 3'd0, 8'b0000_0000);

        // Eat: growth, respawn, single done pulse.
        do_reset();
        food_write(3'd5, 3'd0);
        do_step(d);
        check("eat_len", 32'(length), 32'd2);
        check("eat_done_cnt", 32'(d), 32'd1);
        check_head("eat_head", 3'd5, 3'd0);
        tick();
        check("eat_done_low", 32'(done), 32'd0);
        check_row("eat_row0", 3'd0, 8'b0000_1100);
        check("eat_food_moved", 32'({food_x, food_y} == {3'd5, 3'd0}), 32'd0);
        check_food_free("eat_food_free");

        // Grow to 5 then coil into the body.
        for (int i = 0; i < 3; i++) begin
            food_write(3'((6 + i) % 8), 3'd0);
            do_step(d);
            check("grow_len", 32'(length), 32'(3 + i));
        end
        check_head("grow_head", 3'd0, 3'd0);
        food_write(3'd2, 3'd5);
        set_dir(2'd2);
        do_step(d);
        check_head("coil_down", 3'd0, 3'd1);
        set_dir(2'd3);
        do_step(d);
        check_head("coil_left", 3'd7, 3'd1);
        check_row("coil_row0", 3'd0, 8'b1000_0011);
        check_row("coil_row1", 3'd1, 8'b1000_0001);
        set_dir(2'd0);
        do_step(d);
        check("die_done_cnt", 32'(d), 32'd1);
        check("die_alive", 32'(alive), 32'd0);
        check_head("die_head", 3'd7, 3'd1);
        check("die_len", 32'(length), 32'd5);
        check_row("die_row0", 3'd0, 8'b1000_0011);
        check_row("die_row1", 3'd1, 8'b1000_0001);
        do_step(d);
        check("dead_step_done", 32'(d), 32'd0);
        check_head("dead_head", 3'd7, 3'd1);
        check_row("dead_row0", 3'd0, 8'b1000_0011);
        food_write(3'd1, 3'd1);
        check("dead_food", 32'({food_x, food_y}), 32'({3'd2, 3'd5}));

        // Reset mid-step, then a step held through a move.
        do_reset();
        step = 1'b1;
        tick();
        step  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_head("midrst_head", 3'd4, 3'd0);
        check("midrst_len", 32'(length), 32'd1);
        check("midrst_alive", 32'(alive), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd1);
        check_row("midrst_row0", 3'd0, 8'b0000_1000);
        wait_idle("midrst_idle");
        step = 1'b1;
        tick();
        tick();
        tick();
        step = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_head("held_step_head", 3'd5, 3'd0);
        check("held_step_len", 32'(length), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
